enqueue_arbiter: RTL



---
 rtl/arb_pkg.sv | 20 ++
 rtl/enqueue_arbiter_rr_select.sv | 35 +++
 rtl/enqueue_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------------+
// | arb_pkg : shared state encoding and default sizes for enqueue_arbiter       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENQ  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int QUEUE_DEPTH_DEF = 8;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/enqueue_arbiter_rr_select.sv
// +----------------------------------------------------------------------------+
// | rr_select : combinational round-robin finder, searches last+1, last+2, ...  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_select #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] ready,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  // Walk from the farthest candidate to the nearest so the nearest asserted
  // request after 'last' is the one left standing.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    index = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (ready[cand]) begin
        valid = 1'b1;
        index = IDX_W'(cand);
      end
    end
  end

endmodule : rr_select

`default_nettype wire

// File: rtl/enqueue_arbiter.sv
// +----------------------------------------------------------------------------+
// | enqueue_arbiter : round-robin share of one queue enqueue port among         |
// | NUM_REQ four-phase data_ready/ack channels.  Revision: 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module enqueue_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ     = 2,
  parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter  int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                               clock_1MHz,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 ready_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]                 ack_out,
  input  logic [7:0]                         len_in,
  output logic                               enqueue_out,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [IDX_W-1:0]                   grant_out,
  output logic                               busy_out,
  output logic [15:0]                        served_count_out
);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       last_q,  last_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  data_q,  data_d;
  logic [NUM_REQ-1:0]     ack_q,   ack_d;
  logic [15:0]            count_q, count_d;

  logic                   sel_valid;
  logic [IDX_W-1:0]       sel_idx;
  logic                   len_ok;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .ready (ready_in),
    .last  (last_q),
    .valid (sel_valid),
    .index (sel_idx)
  );

  assign len_ok = (32'(len_in) < 32'(QUEUE_DEPTH));

  always_ff @(posedge clock_1MHz) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = ack_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (sel_valid && (ack_q == '0) && len_ok) begin
          state_d = ENQ;
          data_d  = data_in[sel_idx];
          grant_d = sel_idx;
          last_d  = sel_idx;
        end
      end
      ENQ: begin
        state_d         = ACK;
        count_d         = count_q + 16'd1;
        ack_d           = '0;
        ack_d[grant_q]  = 1'b1;
      end
      ACK: begin
        // Only the granted channel is watched; others wait for the next IDLE.
        if (!ready_in[grant_q]) begin
          ack_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = '0;
      end
    endcase
  end

  always_comb begin
    enqueue_out      = (state_q == ENQ);
    busy_out         = (state_q == ENQ) || (state_q == ACK);
    ack_out          = ack_q;
    data_out         = data_q;
    grant_out        = grant_q;
    served_count_out = count_q;
  end

endmodule : enqueue_arbiter

`default_nettype wire
